// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: sequenced initiator for the 256-byte RAM bus (setup, strobe, wait, capture).
// Define RAM_ALIGN_CHECK_EN to reject misaligned halfword/word requests without touching the bus.
module ram_access_ctrl #(
    parameter int READ_LAT    = 2,
    parameter int MOC_TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_i,
    input  logic        req_wr_i,
    input  logic [1:0]  req_mode_i,
    input  logic        req_signed_i,
    input  logic [7:0]  req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic [7:0]  ram_addr_o,
    output logic [31:0] ram_data_o,
    output logic        ram_w_r_o,
    output logic        ram_enable_o,
    output logic [1:0]  ram_mode_o,
    input  logic        ram_moc_i,
    input  logic [31:0] ram_rdata_i
);
    localparam int CW = $clog2((READ_LAT > MOC_TIMEOUT ? READ_LAT : MOC_TIMEOUT) + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t        state_q, state_d;
    logic          wr_q, wr_d;
    logic [1:0]    mode_q, mode_d;
    logic          signed_q, signed_d;
    logic [7:0]    addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          en_q, en_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          bad, rd_last, wr_ok, wr_to;
    logic [31:0]   ext;

`ifdef RAM_ALIGN_CHECK_EN
    assign bad = (req_mode_i == 2'b11) || (req_mode_i == 2'b01 && req_addr_i[0])
              || (req_mode_i == 2'b10 && req_addr_i[1:0] != 2'b00);
`else
    assign bad = req_mode_i == 2'b11;
`endif

    assign ext = mode_q == 2'b00 ? {{24{signed_q & ram_rdata_i[7]}}, ram_rdata_i[7:0]}
               : mode_q == 2'b01 ? {{16{signed_q & ram_rdata_i[15]}}, ram_rdata_i[15:0]}
               : ram_rdata_i;
    assign rd_last = state_q == ACCESS && !wr_q && cnt_q == CW'(READ_LAT);
    // moc only counts once the strobe is actually up
    assign wr_ok   = state_q == ACCESS && wr_q && en_q && ram_moc_i;
    assign wr_to   = state_q == ACCESS && wr_q && cnt_q == CW'(MOC_TIMEOUT);

    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        mode_d   = mode_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        unique case (state_q)
            IDLE: if (req_i) begin
                wr_d     = req_wr_i;
                mode_d   = req_mode_i;
                signed_d = req_signed_i;
                addr_d   = req_addr_i;
                wdata_d  = req_wdata_i;
                state_d  = bad ? DONE : SETUP;
                err_d    = bad;
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                cnt_d = cnt_q + CW'(1);
                if (rd_last) begin
                    rdata_d = ext;
                    state_d = DONE;
                end else if (wr_ok) begin
                    state_d = DONE;
                end else if (wr_to) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // strobe rises one cycle into ACCESS and falls as DONE is entered
        en_d = state_q == ACCESS && state_d == ACCESS;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            wr_q     <= 1'b0;
            mode_q   <= 2'b10;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            en_q     <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            mode_q   <= mode_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            en_q     <= en_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign busy_o       = state_q != IDLE;
    assign done_o       = state_q == DONE;
    assign err_o        = err_q;
    assign rdata_o      = rdata_q;
    assign ram_addr_o   = addr_q;
    assign ram_data_o   = wdata_q;
    assign ram_w_r_o    = ~wr_q;
    assign ram_enable_o = en_q;
    assign ram_mode_o   = mode_q;
endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: directed vectors against a big-endian RAM model with delayed MOC.
module tb_ram_access_ctrl;
    logic        clk = 1'b0, reset = 1'b1, req = 1'b0, req_wr = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_mode = 2'b00;
    logic [7:0]  req_addr = 8'h00;
    logic [31:0] req_wdata = 32'h0;
    logic        busy, done, err, ram_w_r, ram_enable, ram_moc = 1'b0;
    logic [31:0] rdata, ram_data, ram_rdata = 32'h0;
    logic [7:0]  ram_addr;
    logic [1:0]  ram_mode;
    logic [7:0]  mem [256];
    logic        moc_en = 1'b1;
    int          rises = 0;
    logic        cap_wr;
    logic [1:0]  cap_mode;
    logic [7:0]  cap_addr;
    logic [31:0] cap_data;
    int          checks = 0, errors = 0;

    ram_access_ctrl dut (
        .clk_i(clk), .reset_i(reset), .req_i(req), .req_wr_i(req_wr), .req_mode_i(req_mode),
        .req_signed_i(req_signed), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .busy_o(busy), .done_o(done), .err_o(err), .rdata_o(rdata), .ram_addr_o(ram_addr),
        .ram_data_o(ram_data), .ram_w_r_o(ram_w_r), .ram_enable_o(ram_enable),
        .ram_mode_o(ram_mode), .ram_moc_i(ram_moc), .ram_rdata_i(ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM model: acts on the strobe's rising edge, raises moc one clock later on writes
    always @(posedge ram_enable) begin
        logic [7:0] a;
        rises++;
        cap_wr = ram_w_r; cap_mode = ram_mode; cap_addr = ram_addr; cap_data = ram_data;
        a = ram_addr;
        if (!ram_w_r) begin
            if (ram_mode == 2'b00) mem[a] = ram_data[7:0];
            else if (ram_mode == 2'b01) begin
                mem[a] = ram_data[15:8]; mem[a + 8'd1] = ram_data[7:0];
            end else begin
                mem[a] = ram_data[31:24]; mem[a + 8'd1] = ram_data[23:16];
                mem[a + 8'd2] = ram_data[15:8]; mem[a + 8'd3] = ram_data[7:0];
            end
            @(posedge clk);
            #1 ram_moc = moc_en;
        end else begin
            if (ram_mode == 2'b00) ram_rdata = {24'h0, mem[a]};
            else if (ram_mode == 2'b01) ram_rdata = {16'h0, mem[a], mem[a + 8'd1]};
            else ram_rdata = {mem[a], mem[a + 8'd1], mem[a + 8'd2], mem[a + 8'd3]};
        end
        @(negedge ram_enable);
        ram_moc = 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one request, then scrambles the req_* inputs to prove they were latched
    task automatic do_req(input logic w, input logic [1:0] m, input logic s, input logic [7:0] a,
                          input logic [31:0] d, output int lat, output logic e, output int nr,
                          output logic en_done, output logic busy_after, output logic done_after);
        int r0;
        r0 = rises;
        @(negedge clk);
        req = 1'b1; req_wr = w; req_mode = m; req_signed = s; req_addr = a; req_wdata = d;
        @(negedge clk);
        req = 1'b0; req_wr = ~w; req_mode = ~m; req_signed = ~s; req_addr = ~a; req_wdata = ~d;
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        e = err; en_done = ram_enable;
        @(negedge clk);
        busy_after = busy; done_after = done; nr = rises - r0;
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  mode;
        logic        sgn;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        xerr;
        int          xlat;
        int          xrises;
        logic [31:0] xrdata;
    } vec_t;

    vec_t v[12];

    initial begin
        int lat, nr, dn;
        logic e, en_d, b_a, d_a;
        foreach (mem[i]) mem[i] = 8'h00;
        v[0]  = '{1'b1, 2'b10, 1'b0, 8'h08, 32'hCACABABA, 1'b0, 4, 1, 32'h00000000};
        v[1]  = '{1'b0, 2'b10, 1'b0, 8'h08, 32'h0,        1'b0, 4, 1, 32'hCACABABA};
        v[2]  = '{1'b1, 2'b00, 1'b0, 8'h00, 32'h000000F0, 1'b0, 4, 1, 32'hCACABABA};
        v[3]  = '{1'b0, 2'b00, 1'b0, 8'h00, 32'h0,        1'b0, 4, 1, 32'h000000F0};
        v[4]  = '{1'b0, 2'b00, 1'b1, 8'h00, 32'h0,        1'b0, 4, 1, 32'hFFFFFFF0};
        v[5]  = '{1'b1, 2'b01, 1'b0, 8'h02, 32'h00008001, 1'b0, 4, 1, 32'hFFFFFFF0};
        v[6]  = '{1'b0, 2'b01, 1'b1, 8'h02, 32'h0,        1'b0, 4, 1, 32'hFFFF8001};
        v[7]  = '{1'b0, 2'b01, 1'b0, 8'h02, 32'h0,        1'b0, 4, 1, 32'h00008001};
        v[8]  = '{1'b0, 2'b11, 1'b0, 8'h04, 32'h0,        1'b1, 0, 0, 32'h00008001};
        v[9]  = '{1'b0, 2'b10, 1'b1, 8'h08, 32'h0,        1'b0, 4, 1, 32'hCACABABA};
`ifdef RAM_ALIGN_CHECK_EN
        v[10] = '{1'b0, 2'b01, 1'b0, 8'h03, 32'h0,        1'b1, 0, 0, 32'hCACABABA};
`else
        v[10] = '{1'b0, 2'b01, 1'b0, 8'h03, 32'h0,        1'b0, 4, 1, 32'h00000100};
`endif
        v[11] = '{1'b0, 2'b00, 1'b1, 8'h09, 32'h0,        1'b0, 4, 1, 32'hFFFFFFCA};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_done", {31'h0, done}, 32'h0);
        chk("reset_err", {31'h0, err}, 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_enable", {31'h0, ram_enable}, 32'h0);
        chk("reset_w_r", {31'h0, ram_w_r}, 32'h1);
        chk("reset_addr", {24'h0, ram_addr}, 32'h0);
        chk("reset_data", ram_data, 32'h0);
        chk("reset_mode", {30'h0, ram_mode}, 32'h2);

        for (int i = 0; i < 12; i++) begin
            do_req(v[i].wr, v[i].mode, v[i].sgn, v[i].addr, v[i].wdata, lat, e, nr, en_d, b_a, d_a);
            chk($sformatf("v%0d_err", i), {31'h0, e}, {31'h0, v[i].xerr});
            chk($sformatf("v%0d_latency", i), lat, v[i].xlat);
            chk($sformatf("v%0d_strobes", i), nr, v[i].xrises);
            chk($sformatf("v%0d_rdata", i), rdata, v[i].xrdata);
            chk($sformatf("v%0d_enable_in_done", i), {31'h0, en_d}, 32'h0);
            chk($sformatf("v%0d_done_one_cycle", i), {30'h0, d_a, b_a}, 32'h0);
            if (v[i].xrises == 1) begin
                chk($sformatf("v%0d_bus_addr", i), {24'h0, cap_addr}, {24'h0, v[i].addr});
                chk($sformatf("v%0d_bus_mode", i), {30'h0, cap_mode}, {30'h0, v[i].mode});
                chk($sformatf("v%0d_bus_w_r", i), {31'h0, cap_wr}, {31'h0, ~v[i].wr});
                if (v[i].wr) chk($sformatf("v%0d_bus_data", i), cap_data, v[i].wdata);
            end
        end
        chk("ram_bytes_8_11", {mem[8], mem[9], mem[10], mem[11]}, 32'hCACABABA);

        moc_en = 1'b0;
        do_req(1'b1, 2'b10, 1'b0, 8'h10, 32'h11223344, lat, e, nr, en_d, b_a, d_a);
        chk("timeout_err", {31'h0, e}, 32'h1);
        chk("timeout_latency", lat, 17);
        chk("timeout_enable_in_done", {31'h0, en_d}, 32'h0);
        chk("timeout_strobes", nr, 1);
        moc_en = 1'b1;

        dn = 0;
        @(negedge clk);
        req = 1'b1; req_wr = 1'b0; req_mode = 2'b10; req_addr = 8'h08;
        @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("busy_req_ignored", dn, 1);

        @(negedge clk);
        req = 1'b1; req_wr = 1'b0; req_mode = 2'b10; req_addr = 8'h08;
        @(negedge clk);
        req = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_reset_enable", {31'h0, ram_enable}, 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_enable", {31'h0, ram_enable}, 32'h0);
        chk("async_reset_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        dn = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("reset_no_done", dn, 0);
        chk("reset_rdata_cleared", rdata, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
